// File: rtl/usr_rx.sv
// Framed serial receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// Good frames land in a one-entry valid/ready output buffer.
module usr_rx #(
  parameter int WIDTH     = 5,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             si,
  input  logic             si_en,
  input  logic             msb_first,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] sh, sh_nx;
  logic [WIDTH-1:0] po_nx;
  logic             msb, msb_nx;
  logic             perr, perr_nx;
  logic             valid_nx;
  logic             ferr_nx;
  logic             perr_p_nx;
  logic             ovr_nx;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      msb        <= 1'b0;
      perr       <= 1'b0;
      po         <= '0;
      po_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      sh         <= sh_nx;
      msb        <= msb_nx;
      perr       <= perr_nx;
      po         <= po_nx;
      po_valid   <= valid_nx;
      frame_err  <= ferr_nx;
      parity_err <= perr_p_nx;
      overrun    <= ovr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    sh_nx     = sh;
    msb_nx    = msb;
    perr_nx   = perr;
    po_nx     = po;
    valid_nx  = po_valid;
    ferr_nx   = 1'b0;
    perr_p_nx = 1'b0;
    ovr_nx    = 1'b0;
    // A commit below overrides this plain accept.
    if (po_valid && po_ready)
      valid_nx = 1'b0;
    if (si_en) begin
      unique case (state)
        IDLE: begin
          if (!si) begin
            state_nx = DATA;
            cnt_nx   = '0;
            msb_nx   = msb_first;
            perr_nx  = 1'b0;
          end
        end
        DATA: begin
          if (msb)
            sh_nx = {sh[WIDTH-2:0], si};
          else
            sh_nx = {si, sh[WIDTH-1:1]};
          cnt_nx = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            if (PARITY_EN)
              state_nx = PARITY;
            else
              state_nx = STOP;
          end
        end
        PARITY: begin
          perr_nx  = (si != ^sh);
          state_nx = STOP;
        end
        STOP: begin
          state_nx = IDLE;
          if (!si)
            ferr_nx = 1'b1;
          else if (perr)
            perr_p_nx = 1'b1;
          else if (!po_valid || po_ready) begin
            po_nx    = sh;
            valid_nx = 1'b1;
          end else
            ovr_nx = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: doc/usr_rx.md
Name: usr_rx

Overview:
- Serial-in, parallel-out receiver for the framed serial stream produced by the universal shift register's serial output.
- Detects a start bit, shifts in WIDTH data bits (MSB-first or LSB-first), then checks an optional even-parity bit and a stop bit.
- Presents the assembled word on a valid/ready output buffer.
- Sits on the receive end of the serial link, feeding parallel consumers.

Parameters:
- WIDTH, 5, data bits per frame (>=2).
- PARITY_EN, 1, 1 = even-parity bit follows data; 0 = no parity bit.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- si  input  1  serial data in; line idles high.
- si_en  input  1  bit strobe; si is sampled only on edges where si_en=1.
- msb_first  input  1  1 = first data bit is po[WIDTH-1]; 0 = first data bit is po[0].
- po  output  WIDTH  received word.
- po_valid  output  1  po holds an unconsumed word.
- po_ready  input  1  consumer accepts po when po_valid=1 at a clock edge.
- busy  output  1  frame reception in progress (state != IDLE).
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- parity_err  output  1  one-cycle pulse: parity mismatch.
- overrun  output  1  one-cycle pulse: good frame completed while buffer full and not draining.

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - po=0, po_valid=0, busy=0, all error pulses 0, state=IDLE, bit counter=0, shift register=0.
  - Reset mid-frame aborts the frame; no partial word is ever delivered.
- States:
  - IDLE: si_en & si=0 -> DATA, cnt=0, latch msb_first for the whole frame. si=1 stays in IDLE.
  - DATA: on each si_en, shift.
    - MSB-first: sh <= {sh[WIDTH-2:0], si}.
    - LSB-first: sh <= {si, sh[WIDTH-1:1]}.
    - cnt increments per shift; after the WIDTH-th bit -> PARITY if PARITY_EN, else STOP.
  - PARITY: on si_en, record perr = si != ^sh (even parity: data + parity bit has an even number of ones) -> STOP.
  - STOP: on si_en -> IDLE always.
    - si=0: frame_err pulse; word discarded.
    - si=1 and perr: parity_err pulse; word discarded.
    - si=1 and no perr: commit.
- Edges with si_en=0 hold state, counter and shift register. Gaps of any length between bits are legal.
- Commit, evaluated at the STOP-sampling edge:
  - Buffer free (po_valid=0) or draining (po_valid & po_ready): po<=sh, po_valid<=1. Visible the cycle after the stop edge.
  - Buffer full and po_ready=0: word dropped, po unchanged, overrun pulse.
- Handshake:
  - po_valid clears on an edge where po_valid & po_ready and no commit occurs.
  - Simultaneous accept and commit: po_valid stays 1 with the new word.
  - po is stable while po_valid=1 and po_ready=0.
- Error pulses:
  - Registered and high for exactly one cycle following the triggering edge.
  - At most one error type per frame; frame_err takes priority over parity_err.
- busy=1 from the edge after start detection until the edge that samples the stop bit.
- Back-to-back: a start bit may be sampled on the first si_en edge after the stop edge.

Test Plan (WIDTH=5, PARITY_EN=1, si_en=1 every cycle unless noted):
- Async reset:
  - Stimulus: drive rst=0 mid-frame, between clock edges.
  - Required: po=00000, po_valid=0, busy=0 immediately.
  - After rst=1 and a clean frame: correct word received.
- MSB-first good frame:
  - Stimulus: msb_first=1, si sequence 0,1,1,0,1,0,1,1 (start, data 11010, parity 1, stop).
  - Required: po=11010, po_valid=1 the cycle after the stop edge; no error pulses.
  - Then po_ready=1 for one edge: po_valid=0.
- LSB-first good frame:
  - Stimulus: msb_first=0, si 0,0,1,0,1,1,1,1.
  - Required: po=11010, po_valid=1.
- Framing and parity errors:
  - Stimulus: MSB frame 11010 with stop=0.
  - Required: frame_err one-cycle pulse; po_valid stays 0; busy=0 next cycle.
  - Stimulus: frame with parity bit 0.
  - Required: parity_err pulse only; no word delivered.
- Overrun and simultaneous accept:
  - Stimulus: po_ready=0, frames 11010 then 00111 (parity 1).
  - Required: overrun pulse; po stays 11010.
  - Stimulus: third frame 10000 with po_ready=1 on its stop edge.
  - Required: po=10000, po_valid remains 1.
- si_en gaps:
  - Stimulus: frame 11010 with si_en=0 for 3 cycles between every bit; si toggling randomly while si_en=0.
  - Required: po=11010, no errors.
